// File: rtl/barrel_shift_ctrl_if.sv
// rtl/barrel_shift_ctrl_if.sv - request, shifter and result signals of the barrel shift controller
interface barrel_shift_ctrl_if #(
  parameter int AMT_W = 4
);
  logic             req0_valid;
  logic [7:0]       req0_din;
  logic [AMT_W-1:0] req0_amt;
  logic             req0_ready;

  logic             req1_valid;
  logic [7:0]       req1_din;
  logic [AMT_W-1:0] req1_amt;
  logic             req1_ready;

  logic [7:0]       sh_din;
  logic [2:0]       sh_sel;
  logic [7:0]       sh_dout;

  logic             res_valid;
  logic [7:0]       res_dout;
  logic             res_id;
  logic             res_ready;

  // controller side
  modport slave (
    input  req0_valid, req0_din, req0_amt,
    output req0_ready,
    input  req1_valid, req1_din, req1_amt,
    output req1_ready,
    output sh_din, sh_sel,
    input  sh_dout,
    output res_valid, res_dout, res_id,
    input  res_ready
  );

  // requesters, shifter and result consumer side
  modport master (
    output req0_valid, req0_din, req0_amt,
    input  req0_ready,
    output req1_valid, req1_din, req1_amt,
    input  req1_ready,
    input  sh_din, sh_sel,
    output sh_dout,
    input  res_valid, res_dout, res_id,
    output res_ready
  );
endinterface

// File: rtl/barrel_shift_ctrl.sv
// rtl/barrel_shift_ctrl.sv - round-robin scheduler and multi-pass sequencer for a shared 8-bit barrel shifter
module barrel_shift_ctrl #(
  parameter int AMT_W    = 4,
  parameter int STEP_MAX = 7
) (
  input logic                clk,
  input logic                rst,
  barrel_shift_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [AMT_W-1:0] STEP_MAX_W = AMT_W'(STEP_MAX);

  state_t           state_r,  state_nxt;
  logic [7:0]       data_r,   data_nxt;
  logic [AMT_W-1:0] rem_r,    rem_nxt;
  logic             id_r,     id_nxt;
  logic             prio_r,   prio_nxt;

  logic             grant_any;
  logic             grant_id;
  logic [2:0]       step;
  logic [AMT_W-1:0] rem_left;

  // round-robin arbitration: a lone requester always wins, a tie goes to prio_r
  always_comb begin
    grant_any = bus.req0_valid | bus.req1_valid;
    grant_id  = (bus.req0_valid & bus.req1_valid) ? prio_r : bus.req1_valid;
  end

  // per-pass shift amount is clipped to what the shifter can do in one go
  always_comb begin
    step     = (rem_r > STEP_MAX_W) ? 3'(STEP_MAX) : rem_r[2:0];
    rem_left = rem_r - AMT_W'(step);
  end

  // next-state, datapath update and output decode
  always_comb begin
    state_nxt      = state_r;
    data_nxt       = data_r;
    rem_nxt        = rem_r;
    id_nxt         = id_r;
    prio_nxt       = prio_r;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.sh_din     = data_r;
    bus.sh_sel     = 3'd0;
    bus.res_valid  = 1'b0;
    bus.res_dout   = 8'h00;
    bus.res_id     = 1'b0;

    case (state_r)
      IDLE: begin
        // ready is suppressed while reset is held so nothing is offered before release
        if (grant_any && !rst) begin
          bus.req0_ready = ~grant_id;
          bus.req1_ready = grant_id;
          data_nxt       = grant_id ? bus.req1_din : bus.req0_din;
          rem_nxt        = grant_id ? bus.req1_amt : bus.req0_amt;
          id_nxt         = grant_id;
          prio_nxt       = ~grant_id;
          state_nxt      = SHIFT;
        end
      end
      SHIFT: begin
        // a zero amount still makes one pass with select 0
        bus.sh_sel = step;
        data_nxt   = bus.sh_dout;
        rem_nxt    = rem_left;
        if (rem_left == '0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        bus.res_valid = 1'b1;
        bus.res_dout  = data_r;
        bus.res_id    = id_r;
        if (bus.res_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // state and datapath registers; reset drops any in-flight operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      data_r  <= 8'h00;
      rem_r   <= '0;
      id_r    <= 1'b0;
      prio_r  <= 1'b0;
    end else begin
      state_r <= state_nxt;
      data_r  <= data_nxt;
      rem_r   <= rem_nxt;
      id_r    <= id_nxt;
      prio_r  <= prio_nxt;
    end
  end

endmodule

// File: tb/tb_barrel_shift_ctrl.sv
// tb/tb_barrel_shift_ctrl.sv - directed self-checking bench for barrel_shift_ctrl
module tb_barrel_shift_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  barrel_shift_ctrl_if #(.AMT_W(4)) bus ();

  barrel_shift_ctrl #(.AMT_W(4), .STEP_MAX(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // the shared shifter itself
  assign bus.sh_dout = bus.sh_din << bus.sh_sel;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // starts and ends on a falling edge; holds valid until the grant edge has passed
  task automatic send(input bit id, input logic [7:0] din, input logic [3:0] amt, output bit got);
    got = 1'b0;
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_din = din; bus.req1_amt = amt;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_din = din; bus.req0_amt = amt;
    end
    for (int i = 0; i < 10 && !got; i++) begin
      #1;
      if (id ? bus.req1_ready : bus.req0_ready) got = 1'b1;
      @(negedge clk);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  // records the select of each pass until the result shows up; ends 1 time unit after a falling edge
  task automatic collect(output int n, output logic [11:0] sels, output bit done);
    n = 0; sels = '0; done = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      #1;
      if (bus.res_valid) begin
        done = 1'b1;
      end else begin
        if (n < 4) sels[n*3 +: 3] = bus.sh_sel;
        n++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    bit got;
    int seen;
    #1;
    total++; if (bus.res_valid !== 1'b0 || bus.res_dout !== 8'h00 || bus.res_id !== 1'b0) begin bad++;
      $display("FAIL reset_res: valid=%b dout=%h id=%b, want 0/00/0", bus.res_valid, bus.res_dout, bus.res_id); end
    total++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin bad++;
      $display("FAIL reset_ready: r0=%b r1=%b, want 0/0", bus.req0_ready, bus.req1_ready); end
    total++; if (bus.sh_din !== 8'h00 || bus.sh_sel !== 3'd0) begin bad++;
      $display("FAIL reset_sh: din=%h sel=%0d, want 00/0", bus.sh_din, bus.sh_sel); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(1'b0, 8'h81, 4'd15, got);
    total++; if (got !== 1'b1) begin bad++; $display("FAIL reset_grant: got=%b, want 1", got); end
    #1;
    total++; if (bus.sh_sel !== 3'd7) begin bad++; $display("FAIL reset_midshift_sel: got %0d, want 7", bus.sh_sel); end
    rst = 1'b1;
    #1;
    total++; if (bus.sh_sel !== 3'd0 || bus.sh_din !== 8'h00) begin bad++;
      $display("FAIL reset_async_sh: sel=%0d din=%h, want 0/00", bus.sh_sel, bus.sh_din); end
    total++; if (bus.res_valid !== 1'b0 || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin bad++;
      $display("FAIL reset_async_out: valid=%b r0=%b r1=%b, want 0", bus.res_valid, bus.req0_ready, bus.req1_ready); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (bus.res_valid || bus.sh_sel != 3'd0) seen++;
      @(negedge clk);
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL reset_no_result: active cycles=%0d, want 0", seen); end
  endtask

  task automatic test_single();
    bit got, done; int n; logic [11:0] sels;
    send(1'b0, 8'h81, 4'd3, got);
    total++; if (got !== 1'b1) begin bad++; $display("FAIL single_grant: got=%b, want 1", got); end
    collect(n, sels, done);
    total++; if (done !== 1'b1 || n !== 1 || sels[2:0] !== 3'd3) begin bad++;
      $display("FAIL single_passes: done=%b n=%0d sel0=%0d, want 1/1/3", done, n, sels[2:0]); end
    total++; if (bus.res_dout !== 8'h08 || bus.res_id !== 1'b0) begin bad++;
      $display("FAIL single_result: dout=%h id=%b, want 08/0", bus.res_dout, bus.res_id); end
    @(negedge clk);
  endtask

  task automatic test_zero();
    bit got, done; int n; logic [11:0] sels;
    send(1'b0, 8'hA5, 4'd0, got);
    collect(n, sels, done);
    total++; if (got !== 1'b1 || done !== 1'b1 || n !== 1 || sels[2:0] !== 3'd0) begin bad++;
      $display("FAIL zero_passes: got=%b done=%b n=%0d sel0=%0d, want 1/1/1/0", got, done, n, sels[2:0]); end
    total++; if (bus.res_dout !== 8'hA5 || bus.res_id !== 1'b0) begin bad++;
      $display("FAIL zero_result: dout=%h id=%b, want a5/0", bus.res_dout, bus.res_id); end
    @(negedge clk);
  endtask

  task automatic test_multi();
    bit got, done; int n; logic [11:0] sels;
    send(1'b0, 8'hFF, 4'd15, got);
    collect(n, sels, done);
    total++; if (got !== 1'b1 || done !== 1'b1 || n !== 3 || sels[8:0] !== {3'd1, 3'd7, 3'd7}) begin bad++;
      $display("FAIL multi15_passes: got=%b done=%b n=%0d sels=%o, want 1/1/3/177", got, done, n, sels[8:0]); end
    total++; if (bus.res_dout !== 8'h00 || bus.res_id !== 1'b0) begin bad++;
      $display("FAIL multi15_result: dout=%h id=%b, want 00/0", bus.res_dout, bus.res_id); end
    @(negedge clk);
    send(1'b1, 8'h01, 4'd10, got);
    collect(n, sels, done);
    total++; if (got !== 1'b1 || done !== 1'b1 || n !== 2 || sels[5:0] !== {3'd3, 3'd7}) begin bad++;
      $display("FAIL multi10_passes: got=%b done=%b n=%0d sels=%o, want 1/1/2/37", got, done, n, sels[5:0]); end
    total++; if (bus.res_dout !== 8'h00 || bus.res_id !== 1'b1) begin bad++;
      $display("FAIL multi10_result: dout=%h id=%b, want 00/1", bus.res_dout, bus.res_id); end
    @(negedge clk);
    send(1'b1, 8'h03, 4'd5, got);
    collect(n, sels, done);
    total++; if (got !== 1'b1 || done !== 1'b1 || n !== 1 || sels[2:0] !== 3'd5) begin bad++;
      $display("FAIL multi5_passes: got=%b done=%b n=%0d sel0=%0d, want 1/1/1/5", got, done, n, sels[2:0]); end
    total++; if (bus.res_dout !== 8'h60 || bus.res_id !== 1'b1) begin bad++;
      $display("FAIL multi5_result: dout=%h id=%b, want 60/1", bus.res_dout, bus.res_id); end
    @(negedge clk);
  endtask

  task automatic test_contention();
    int ng, nr, overlap;
    logic [3:0] g, rid;
    logic [7:0] rd [4];
    ng = 0; nr = 0; overlap = 0; g = '0; rid = '0;
    for (int k = 0; k < 4; k++) rd[k] = 8'h00;
    bus.req0_valid = 1'b1; bus.req0_din = 8'h11; bus.req0_amt = 4'd1;
    bus.req1_valid = 1'b1; bus.req1_din = 8'h22; bus.req1_amt = 4'd2;
    for (int cyc = 0; cyc < 60 && (ng < 4 || nr < 4); cyc++) begin
      #1;
      if (bus.req0_ready && bus.req1_ready) overlap++;
      if (bus.res_valid && nr < 4) begin rid[nr] = bus.res_id; rd[nr] = bus.res_dout; nr++; end
      if ((bus.req0_ready || bus.req1_ready) && ng < 4) begin g[ng] = bus.req1_ready; ng++; end
      @(negedge clk);
      if (ng == 4) begin bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; end
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    total++; if (ng !== 4 || nr !== 4) begin bad++; $display("FAIL contend_count: grants=%0d results=%0d, want 4/4", ng, nr); end
    total++; if (g !== 4'b1010) begin bad++; $display("FAIL contend_order: grants(lsb first)=%b, want 1010", g); end
    total++; if (rid !== 4'b1010) begin bad++; $display("FAIL contend_res_id: ids(lsb first)=%b, want 1010", rid); end
    total++; if (overlap !== 0) begin bad++; $display("FAIL contend_both_ready: cycles=%0d, want 0", overlap); end
    for (int k = 0; k < 4; k++) begin
      total++; if (rd[k] !== ((k % 2 == 0) ? 8'h22 : 8'h88)) begin bad++;
        $display("FAIL contend_dout%0d: got %h, want %h", k, rd[k], (k % 2 == 0) ? 8'h22 : 8'h88); end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit got, done; int n; logic [11:0] sels;
    bus.res_ready = 1'b0;
    send(1'b1, 8'h0F, 4'd4, got);
    collect(n, sels, done);
    total++; if (got !== 1'b1 || done !== 1'b1) begin bad++; $display("FAIL bp_start: got=%b done=%b, want 1/1", got, done); end
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_din = 8'h01; bus.req0_amt = 4'd1;
    bus.req1_valid = 1'b1; bus.req1_din = 8'h02; bus.req1_amt = 4'd1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (bus.res_valid !== 1'b1 || bus.res_dout !== 8'hF0 || bus.res_id !== 1'b1) begin bad++;
        $display("FAIL bp_hold%0d: valid=%b dout=%h id=%b, want 1/f0/1", i, bus.res_valid, bus.res_dout, bus.res_id); end
      total++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin bad++;
        $display("FAIL bp_ready%0d: r0=%b r1=%b, want 0/0", i, bus.req0_ready, bus.req1_ready); end
      @(negedge clk);
    end
    bus.res_ready = 1'b1;
    #1;
    total++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin bad++;
      $display("FAIL bp_retire_ready: r0=%b r1=%b, want 0/0", bus.req0_ready, bus.req1_ready); end
    @(negedge clk);
    #1;
    total++; if (bus.res_valid !== 1'b0 || bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin bad++;
      $display("FAIL bp_next_accept: valid=%b r0=%b r1=%b, want 0/1/0", bus.res_valid, bus.req0_ready, bus.req1_ready); end
    #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_din = 8'h00; bus.req0_amt = 4'd0;
    bus.req1_valid = 1'b0; bus.req1_din = 8'h00; bus.req1_amt = 4'd0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_zero();
    test_multi();
    test_contention();
    test_backpressure();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
